mult_add_rr_arbiter: RTL and testbench

Shares one mult_add pipeline (8-bit signed, s = c + a*b in fixed point, 2-cycle latency, no stall) between N_REQ independent requesters. Grants are round-robin, at most one per clock. Each result is returned on a shared result bus tagged with the originating requester ID. The block sits between the requesting filter/control stages and a single instance of mult_add, which it instantiates internally.

---
 rtl/mult_add_rr_arbiter_pkg.sv | 17 +
 rtl/mult_add_rr_arbiter_if.sv | 32 +++
 rtl/mult_add.sv | 43 ++++
 rtl/mult_add_rr_arbiter_rr_pick.sv | 35 +++
 rtl/mult_add_rr_arbiter.sv | 96 +++++++++
 tb/tb_mult_add_rr_arbiter.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/mult_add_rr_arbiter_pkg.sv
// Shared constants for the mult_add arbiter slice: datapath width, pipeline
// latency, fixed-point shift and the requester ID width helper.
package mult_add_rr_arbiter_pkg;

    localparam int MA_W    = 8;
    localparam int MA_LAT  = 2;
    localparam int MA_FRAC = 7;

    // Smallest width able to encode n distinct IDs, never below one bit.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mult_add_rr_arbiter_if.sv
// Requester-side bus of the arbiter: packed request operands, per-requester
// handshake and the shared tagged result bus.
interface mult_add_rr_arbiter_if
    import mult_add_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = MA_W,
    parameter int ID_W  = id_width(N_REQ)
);

    logic                 en;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*W-1:0]   req_a;
    logic [N_REQ*W-1:0]   req_b;
    logic [N_REQ*W-1:0]   req_c;
    logic                 res_valid;
    logic [ID_W-1:0]      res_id;
    logic [W-1:0]         res_s;
    logic                 idle;

    modport master (
        output en, req_valid, req_a, req_b, req_c,
        input  req_ready, res_valid, res_id, res_s, idle
    );

    modport slave (
        input  en, req_valid, req_a, req_b, req_c,
        output req_ready, res_valid, res_id, res_s, idle
    );

endinterface

// File: rtl/mult_add.sv
// Two-stage signed fixed-point multiply-add, s = (c + (a*b >>> 7)) >> 1,
// no stall and no reset; rdy_out tracks val_in through the pipe.
module mult_add
    import mult_add_rr_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   val_in,
    input  logic signed [MA_W-1:0] a,
    input  logic signed [MA_W-1:0] b,
    input  logic signed [MA_W-1:0] c,
    output logic signed [MA_W-1:0] s,
    output logic                   rdy_out
);

    localparam int PW = 2 * MA_W;

    logic signed [PW-1:0]   p_q;
    logic signed [MA_W-1:0] c_q;
    logic                   val_q;
    logic signed [MA_W:0]   t;
    logic        [MA_W+1:0] u;
    logic signed [MA_W-1:0] s_q;
    logic                   rdy_q;

    always_comb begin
        t = p_q[PW-1:MA_FRAC];
        u = {c_q[MA_W-1], c_q[MA_W-1], c_q} + {t[MA_W], t};
    end

    // NOTE: datapath registers carry no reset; validity travels separately, so
    // stale contents after reset are harmless and the flops stay cheap.
    always_ff @(posedge clk) begin
        p_q   <= PW'(a) * PW'(b);
        c_q   <= c;
        val_q <= val_in;
        s_q   <= u[MA_W:1];
        rdy_q <= val_q;
    end

    assign s       = s_q;
    assign rdy_out = rdy_q;

endmodule

// File: rtl/mult_add_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick
    import mult_add_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    logic [ID_W-1:0] cand;

    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // Scan farthest-first so the candidate closest to ptr wins last.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = ID_W'((int'(ptr_i) + off) % N_REQ);
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
        gnt_o = any_o ? (N_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/mult_add_rr_arbiter.sv
// Round-robin sharing of one mult_add between N_REQ requesters; results come
// back on a shared bus tagged with the requester ID.
module mult_add_rr_arbiter
    import mult_add_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = MA_W,
    parameter int ID_W  = id_width(N_REQ)
) (
    input logic                  clk,
    input logic                  rst,
    mult_add_rr_arbiter_if.slave bus
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt;
    logic [ID_W-1:0]     g_idx;
    logic                any_req;
    logic                grant_ok;
    logic                xfer;
    logic signed [W-1:0] a_mux, b_mux, c_mux;
    logic signed [W-1:0] ma_s;
    logic                ma_rdy_unused;
    logic                busy;
    tag_t                tag_q [MA_LAT];
    tag_t                tag_d [MA_LAT];

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (g_idx),
        .any_o (any_req)
    );

    assign grant_ok      = bus.en & ~rst;
    assign xfer          = grant_ok & any_req;
    assign bus.req_ready = grant_ok ? gnt : '0;

    // Idle cycles feed zeros so the shared multiplier sees no requester data.
    always_comb begin
        a_mux = '0;
        b_mux = '0;
        c_mux = '0;
        if (xfer) begin
            a_mux = bus.req_a[int'(g_idx)*W +: W];
            b_mux = bus.req_b[int'(g_idx)*W +: W];
            c_mux = bus.req_c[int'(g_idx)*W +: W];
        end
    end

    mult_add u_mult_add (
        .clk     (clk),
        .val_in  (xfer),
        .a       (a_mux),
        .b       (b_mux),
        .c       (c_mux),
        .s       (ma_s),
        .rdy_out (ma_rdy_unused)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (g_idx == ID_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
        tag_d[0] = '{valid: xfer, id: g_idx};
        for (int i = 1; i < MA_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < MA_LAT; i++) tag_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            tag_q <= tag_d;
        end
    end

    always_comb begin
        busy = xfer;
        for (int i = 0; i < MA_LAT; i++) busy = busy | tag_q[i].valid;
    end

    assign bus.res_valid = tag_q[MA_LAT-1].valid;
    assign bus.res_id    = tag_q[MA_LAT-1].id;
    assign bus.res_s     = ma_s;
    assign bus.idle      = ~busy;

endmodule

// File: tb/tb_mult_add_rr_arbiter.sv
// Self-checking bench: vector table, hand-written arbitration/enable/reset
// sequences and a scoreboard fed from observed transfers.
module tb_mult_add_rr_arbiter;
    import mult_add_rr_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_add_rr_arbiter_if #(.N_REQ(N), .W(W), .ID_W(IDW)) bus ();

    mult_add_rr_arbiter #(.N_REQ(N), .W(W), .ID_W(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     s;
    } sb_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [7:0]     a, b, c, s;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    bit         mon_on = 1'b0;
    sb_t        sb_q [$];
    sb_t        mon_e;
    logic [N-1:0] mon_fire;
    vec_t       vecs [6];
    logic [N-1:0] pend;
    logic [N-1:0] exp4 [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the contract, done in plain integers.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int p, t, u;
        p = int'($signed(a)) * int'($signed(b));
        t = p >>> 7;
        u = int'($signed(c)) + t;
        return 8'(u >>> 1);
    endfunction

    task automatic set_ops(input int r, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req_a[r*W +: W] = a;
        bus.req_b[r*W +: W] = b;
        bus.req_c[r*W +: W] = c;
    endtask

    task automatic apply_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_valid[v.id] = 1'b1;
        set_ops(int'(v.id), v.a, v.b, v.c);
        #3 check("vec_ready", bus.req_ready, N'(1) << v.id);
        @(negedge clk) bus.req_valid = '0;
        #3 check("vec_early_valid", bus.res_valid, 0);
        @(negedge clk);
        #3;
        check("vec_valid", bus.res_valid, 1);
        check("vec_id", bus.res_id, v.id);
        check("vec_s", bus.res_s, v.s);
        @(negedge clk);
        #3 check("vec_pulse_end", bus.res_valid, 0);
    endtask

    // Scoreboard monitor: samples mid-cycle, before the next rising edge.
    always begin
        @(negedge clk);
        #3;
        if (mon_on) begin
            mon_fire = bus.req_valid & bus.req_ready;
            check("ready_onehot0", $onehot0(bus.req_ready), 1);
            check("idle", bus.idle, (sb_q.size() == 0) && (mon_fire == '0));
            if (bus.res_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_id", bus.res_id, mon_e.id);
                    check("sb_s", bus.res_s, mon_e.s);
                end
            end
            if (rst) sb_q.delete();
            for (int i = 0; i < N; i++)
                if (mon_fire[i])
                    sb_q.push_back('{id: IDW'(i),
                                     s: model(bus.req_a[i*W +: W], bus.req_b[i*W +: W], bus.req_c[i*W +: W])});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd2, 8'h40, 8'h40, 8'h10, 8'h18};
        vecs[1] = '{2'd0, 8'hC0, 8'h40, 8'h00, 8'hF0};
        vecs[2] = '{2'd1, 8'h80, 8'h80, 8'h00, 8'h40};
        vecs[3] = '{2'd3, 8'h7F, 8'h7F, 8'h7F, 8'h7E};
        vecs[4] = '{2'd2, 8'h80, 8'h7F, 8'h80, 8'h80};
        vecs[5] = '{2'd1, 8'h01, 8'hFF, 8'h00, 8'hFF};
        exp4[0] = 4'b1000;
        exp4[1] = 4'b0010;
        exp4[2] = 4'b1000;

        // Reset with requests and enable asserted: ready must stay low.
        rst = 1'b1;
        bus.en = 1'b1;
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;
        @(negedge clk);
        @(negedge clk);
        #3;
        check("rst_ready", bus.req_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_idle", bus.idle, 1);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
        mon_on = 1'b1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // All requesters valid from ptr=0: grants rotate 0,1,2,3,...
        apply_reset();
        for (int r = 0; r < N; r++) set_ops(r, 8'(16*r + 5), 8'(8'h90 + 3*r), 8'(20*r - 30));
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) bus.req_valid = (i < 8) ? '1 : '0;
            #3;
            if (i < 8) check("rr_all_grant", bus.req_ready, N'(1) << (i % N));
            if (i >= 2 && i < 10) begin
                check("rr_all_valid", bus.res_valid, 1);
                check("rr_all_id", bus.res_id, (i - 2) % N);
            end
            if (i == 10) check("rr_all_done", bus.res_valid, 0);
        end

        // ptr=2 with only requesters 1 and 3 valid: 3, 1, 3.
        run_vec(vecs[2]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) bus.req_valid = (i < 3) ? 4'b1010 : 4'b0000;
            #3;
            if (i < 3) check("rr_sparse_grant", bus.req_ready, exp4[i]);
        end

        // Enable drop with requests pending; ptr must hold across the gap.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.en = (i < 2) || (i == 6);
            bus.req_valid = '1;
            #3;
            if (i < 2) check("en_grant", bus.req_ready, N'(1) << i);
            if (i >= 2 && i < 6) check("en_low_ready", bus.req_ready, 0);
            if (i == 2 || i == 3) begin
                check("en_inflight_valid", bus.res_valid, 1);
                check("en_inflight_id", bus.res_id, i - 2);
            end
            if (i == 4 || i == 5) begin
                check("en_low_no_result", bus.res_valid, 0);
                check("en_low_idle", bus.idle, 1);
            end
            if (i == 6) check("en_resume_grant", bus.req_ready, 4'b0100);
        end
        for (int i = 0; i < 3; i++) @(negedge clk) bus.req_valid = '0;

        // Reset right after two back-to-back transfers.
        set_ops(0, 8'h40, 8'h40, 8'h10);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst = (i == 2);
            bus.req_valid = (i < 3 || i == 5) ? '1 : '0;
            #3;
            if (i == 0) check("rst_seq_grant0", bus.req_ready, 4'b1000);
            if (i == 1) check("rst_seq_grant1", bus.req_ready, 4'b0001);
            if (i == 2) check("rst_seq_ready", bus.req_ready, 0);
            if (i == 3 || i == 4 || i == 6) check("rst_seq_dropped", bus.res_valid, 0);
            if (i == 5) check("rst_seq_ptr0", bus.req_ready, 4'b0001);
            if (i == 7) begin
                check("rst_seq_valid", bus.res_valid, 1);
                check("rst_seq_id", bus.res_id, 0);
                check("rst_seq_s", bus.res_s, 8'h18);
            end
            if (i == 8) check("rst_seq_end", bus.res_valid, 0);
        end

        // Random traffic: requesters hold valid and operands until granted.
        pend = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            bus.en = ($urandom_range(0, 7) != 0);
            for (int r = 0; r < N; r++)
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    set_ops(r, 8'($urandom), 8'($urandom), 8'($urandom));
                end
            bus.req_valid = pend;
            #3 pend = pend & ~(bus.req_valid & bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.en = 1'b1;
        repeat (4) @(negedge clk);
        #3 check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
